sram_controller: RTL
====================

# sram_controller

Memory-side responder for the pipeline's MEM stage. Accepts one 32-bit read or write request at a time (`rd_en`/`wr_en`, byte `address`, `write_data`) and serves it from an external 16-bit asynchronous SRAM as two half-word accesses. It drives `ready` low while an access is in progress, and the top level derives the pipeline freeze from `~ready`. Read data is registered and returned to the MEM/WB register path.

## Interface
- `WAIT_CYCLES`, default 5: cycles per half-word phase; legal range 3..15.
- `ADDR_BASE`, default 1024: byte address mapped to SRAM word 0.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `rd_en`  in  1  — read request.
- `wr_en`  in  1  — write request.
- `address`  in  32  — byte address (ALU result).
- `write_data`  in  32  — store data (Val_Rm).
- `read_data`  out  32  — last completed read word.
- `ready`  out  1  — request completes this cycle / controller free.
- `SRAM_DQ`  inout  16  — SRAM data bus.
- `SRAM_ADDR`  out  18  — SRAM half-word address.
- `SRAM_WE_N`  out  1  — write strobe, active low.
- `SRAM_OE_N`, `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1 each — tied 0.

## Operation
- Offset: `off = address - ADDR_BASE` (32-bit, wraps).
- SRAM address: `SRAM_ADDR = {off[18:2], half}`.
  - `half` = 0 for the low 16 bits, 1 for the high 16 bits.
  - `off[1:0]` and `off[31:19]` are ignored. Addresses wrap modulo 2^17 words.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE → LOW when `rd_en | wr_en`. The request is latched: address, data, and write flag.
  - If both enables are high, the request is treated as a write.
  - LOW → HIGH after `WAIT_CYCLES` cycles.
  - HIGH → DONE after `WAIT_CYCLES` cycles.
  - DONE → IDLE unconditionally.
- A 4-bit phase counter counts 0..WAIT_CYCLES-1 and resets to 0 on every phase entry.
- Reads:
  - `SRAM_DQ` is Z.
  - On the last cycle of LOW, `SRAM_DQ` is captured into `read_data[15:0]`.
  - On the last cycle of HIGH, `SRAM_DQ` is captured into `read_data[31:16]`.
  - `read_data` holds its value until the next read capture. Writes never alter it.
- Writes:
  - During LOW, `SRAM_DQ` is driven with the low half; during HIGH, with the high half. It is Z in all other states.
  - `SRAM_WE_N` = 0 only for phase counts 1..WAIT_CYCLES-2, giving one cycle of address setup and one of hold. It is 1 everywhere else.
- `ready`:
  - IDLE: `~(rd_en | wr_en)`.
  - LOW, HIGH: 0.
  - DONE: 1.
- The requester holds its request stable until it sees `ready` = 1. The DONE → IDLE step guarantees the still-present request is not re-issued.
- Reset values: state IDLE, counter 0, `read_data` 0, `SRAM_WE_N` 1, `SRAM_DQ` Z, `SRAM_ADDR` 0. `ready` follows the IDLE rule.
- Reset asserted mid-access aborts immediately. A partial SRAM write may remain; this is acceptable.

## Timing
- Blocking access: request seen in cycle 0.
  - LOW spans cycles 1..W.
  - HIGH spans cycles W+1..2W.
  - DONE is cycle 2W+1, with `ready` = 1.
  - Total is 2W+2 cycles; 12 for W=5.
- Read data is valid from the DONE cycle onward.
- A back-to-back request presented in the cycle after DONE is accepted in IDLE with no dead cycle.

## Configuration
- `SRAM_WRITE_POST_EN` defined: posted writes.
  - A write seen in IDLE gives `ready` = 1 in that same cycle. Address and data are latched, and the FSM runs LOW/HIGH/DONE in the background.
  - While a posted write is in flight, including its DONE, `ready` = `~(rd_en | wr_en)`. A new request waits, then is accepted when the FSM is back in IDLE.
  - The requester presents each request for exactly one `ready` cycle.
- `SRAM_WRITE_POST_EN` undefined: writes block exactly like reads (2W+2 cycles).

## Test plan
- Reset: assert `rst` mid-LOW of a write → `SRAM_WE_N` = 1, `SRAM_DQ` Z, `read_data` = 0, `ready` = 1 with no request.
- Write `0xDEADBEEF` @1024, then read @1024 (W=5) → `SRAM_ADDR` 0 holds `0xBEEF` and 1 holds `0xDEAD`; read returns `0xDEADBEEF`; each access has `ready` low for exactly 11 cycles.
- Write @1028, then @1024+4·2^17 → `SRAM_ADDR` 2/3, then wraps to 0/1; `off[1:0]` = 3 gives the same addresses as 0.
- `SRAM_WE_N` pulse: W=3 → exactly one low cycle per phase, and address stable one cycle before and after.
- `rd_en` & `wr_en` together → a write is performed; `read_data` unchanged.
- With `SRAM_WRITE_POST_EN`: write then immediate read → write has `ready` = 1 in cycle 0; read waits until the write's DONE+1 and completes 2W+2 cycles later, returning the written value.

Source files
------------

// File: rtl/sram_controller_if.sv
// Request-side bus between the pipeline MEM stage and sram_controller.
// Latency: none (wires only). The master drives rd_en/wr_en/address/write_data.
// Backpressure: the slave holds ready low while busy; the master keeps its request stable until ready is high.
//
// Members:
//   rd_en, wr_en  master -> slave  read / write request (both high = write)
//   address       master -> slave  32-bit byte address
//   write_data    master -> slave  32-bit store data
//   read_data     slave  -> master last completed read word
//   ready         slave  -> master request completes this cycle / controller free
interface sram_controller_if;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;

   modport master (output rd_en, wr_en, address, write_data,
                   input  read_data, ready);
   modport slave  (input  rd_en, wr_en, address, write_data,
                   output read_data, ready);
endinterface

// File: rtl/sram_controller.sv
// MEM-stage responder that serves 32-bit requests from a 16-bit async SRAM as two half-word phases.
// Latency: 2*WAIT_CYCLES+2 cycles from request to ready (posted writes report ready in the request cycle).
// Backpressure: ready stays low while an access is running; the requester freezes and holds its request.
//
// Ports:
//   clk, rst    single clock, asynchronous active-high reset
//   mem_bus     request bus (sram_controller_if.slave): rd_en, wr_en, address, write_data, read_data, ready
//   SRAM_DQ     16-bit bidirectional data bus, driven only during write phases
//   SRAM_ADDR   18-bit half-word address {word, half}
//   SRAM_WE_N   write strobe, active low, shortened by one cycle of setup and one of hold
//   SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N   permanently enabled (0)
// Parameters: WAIT_CYCLES (3..15) cycles per half-word phase; ADDR_BASE byte address of SRAM word 0.
// Build option: define SRAM_WRITE_POST_EN to post writes (ready in the request cycle, SRAM access in the background).
module sram_controller #(
   parameter int unsigned WAIT_CYCLES = 5,
   parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
   input  logic               clk,
   input  logic               rst,
   sram_controller_if.slave   mem_bus,
   inout  wire  [15:0]        SRAM_DQ,
   output logic [17:0]        SRAM_ADDR,
   output logic               SRAM_WE_N,
   output logic               SRAM_OE_N,
   output logic               SRAM_CE_N,
   output logic               SRAM_UB_N,
   output logic               SRAM_LB_N
);

`ifdef SRAM_WRITE_POST_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);
   localparam logic [3:0] WE_LAST  = 4'(WAIT_CYCLES - 2);

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  r_cnt;
   logic [16:0] r_word;
   logic [31:0] r_wdata;
   logic        r_is_wr;
   logic [31:0] r_read_data;

   logic        w_req;
   logic        w_accept;
   logic        w_phase_end;
   logic [31:0] w_off;
   logic        w_unused_off;
   logic        w_half;
   logic        w_dq_oe;
   logic        w_we_n;
   logic        w_ready;
   logic [15:0] w_dq_out;

   assign w_req       = mem_bus.rd_en | mem_bus.wr_en;
   assign w_accept    = (r_state == IDLE) && w_req;
   assign w_phase_end = (r_cnt == LAST_CNT);

   // Only bits [18:2] select the SRAM word; the byte offset and the bits above
   // the 2^17-word window are intentionally dropped so addresses wrap.
   assign w_off        = mem_bus.address - ADDR_BASE;
   assign w_unused_off = ^{w_off[31:19], w_off[1:0]};

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_req)       w_next_state = LOW;
         LOW:     if (w_phase_end) w_next_state = HIGH;
         HIGH:    if (w_phase_end) w_next_state = DONE;
         // DONE always returns to IDLE so the request still held by the
         // requester during DONE is not accepted a second time.
         DONE:                     w_next_state = IDLE;
         default:                  w_next_state = IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      w_half  = 1'b0;
      w_dq_oe = 1'b0;
      w_we_n  = 1'b1;
      w_ready = 1'b0;
      case (r_state)
         IDLE: begin
            // A posted write completes from the requester's view on acceptance.
            if (POSTED) w_ready = mem_bus.wr_en | ~mem_bus.rd_en;
            else        w_ready = ~w_req;
         end
         LOW, HIGH: begin
            w_half  = (r_state == HIGH);
            w_dq_oe = r_is_wr;
            // Strobe skips the first and last cycle of each phase so the
            // address is stable one cycle before and after the pulse.
            w_we_n  = ~(r_is_wr && (r_cnt != 4'd0) && (r_cnt <= WE_LAST));
            if (POSTED && r_is_wr) w_ready = ~w_req;
         end
         DONE: begin
            if (POSTED && r_is_wr) w_ready = ~w_req;
            else                   w_ready = 1'b1;
         end
         default: w_ready = 1'b0;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= 4'd0;
         r_word      <= 17'd0;
         r_wdata     <= 32'd0;
         r_is_wr     <= 1'b0;
         r_read_data <= 32'd0;
      end else begin
         // Counter restarts on every phase entry, including LOW -> HIGH.
         if ((r_state == LOW || r_state == HIGH) && !w_phase_end) r_cnt <= r_cnt + 4'd1;
         else                                                     r_cnt <= 4'd0;

         if (w_accept) begin
            r_word  <= w_off[18:2];
            r_wdata <= mem_bus.write_data;
            r_is_wr <= mem_bus.wr_en;
         end

         // Sample each half at the end of its phase, when the SRAM output has
         // had the full phase to settle.
         if (!r_is_wr && w_phase_end) begin
            if (r_state == LOW)  r_read_data[15:0]  <= SRAM_DQ;
            if (r_state == HIGH) r_read_data[31:16] <= SRAM_DQ;
         end
      end
   end

   assign w_dq_out = w_half ? r_wdata[31:16] : r_wdata[15:0];

   assign SRAM_DQ   = w_dq_oe ? w_dq_out : 16'bz;
   assign SRAM_ADDR = {r_word, w_half};
   assign SRAM_WE_N = w_we_n;
   assign SRAM_OE_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

   assign mem_bus.read_data = r_read_data;
   assign mem_bus.ready     = w_ready;

endmodule
